// File: rtl/mul_arbiter_pkg.sv
// Shared constants and FSM state encoding for the multiplier arbiter.
package mul_arbiter_pkg;

  // Default operand/result width.
  localparam int unsigned WORD = 64;

  // Arbiter FSM states, 3-bit encoding.
  typedef enum logic [2:0] {
    MARB_IDLE      = 3'd0,
    MARB_LAUNCH    = 3'd1,
    MARB_WAIT_BUSY = 3'd2,
    MARB_WAIT_DONE = 3'd3,
    MARB_RESP      = 3'd4
  } marb_state_e;

endpackage

// File: rtl/mul_arb_pick.sv
// Combinational winner selection between two requesters.
// MUL_ARB_RR_EN defined: round-robin using ptr (1 favours requester 1).
// MUL_ARB_RR_EN undefined: fixed priority, requester 0 always wins.
module mul_arb_pick (
  input  logic       req0,
  input  logic       req1,
`ifdef MUL_ARB_RR_EN
  input  logic       ptr,
`endif
  output logic [1:0] win_c
);

  // One-hot winner; zero when nobody requests.
  always_comb begin
    win_c = 2'b00;
`ifdef MUL_ARB_RR_EN
    if (req1 && (!req0 || ptr)) begin
      win_c = 2'b10;
    end else if (req0) begin
      win_c = 2'b01;
    end
`else
    if (req0) begin
      win_c = 2'b01;
    end else if (req1) begin
      win_c = 2'b10;
    end
`endif
  end

endmodule

// File: rtl/mul_arbiter.sv
// Two-requester arbiter in front of a shared iterative multiplier.
// Optional feature: define MUL_ARB_RR_EN for round-robin arbitration;
// otherwise requester 0 has fixed priority.
module mul_arbiter
  import mul_arbiter_pkg::*;
#(
  parameter int unsigned SIZE     = WORD,
  parameter int unsigned WAIT_MAX = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req0,
  input  logic            req1,
  input  logic [SIZE-1:0] a0,
  input  logic [SIZE-1:0] b0,
  input  logic [SIZE-1:0] a1,
  input  logic [SIZE-1:0] b1,
  output logic            gnt0,
  output logic            gnt1,
  output logic            done0,
  output logic            done1,
  output logic [SIZE-1:0] result,
  output logic            mul_start,
  output logic [SIZE-1:0] mul_a,
  output logic [SIZE-1:0] mul_b,
  input  logic [SIZE-1:0] mul_result,
  input  logic            mul_stall,
  output logic            err
);

  localparam int unsigned CW = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX);

  marb_state_e   state;
  logic [CW-1:0] wait_cnt;
  logic [1:0]    win_c;

`ifdef MUL_ARB_RR_EN
  logic rr_ptr;

  mul_arb_pick u_pick (
    .req0  (req0),
    .req1  (req1),
    .ptr   (rr_ptr),
    .win_c (win_c)
  );
`else
  mul_arb_pick u_pick (
    .req0  (req0),
    .req1  (req1),
    .win_c (win_c)
  );
`endif

  // Arbitration FSM with registered grant, launch, response and error outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= MARB_IDLE;
      wait_cnt  <= '0;
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      done0     <= 1'b0;
      done1     <= 1'b0;
      mul_start <= 1'b0;
      err       <= 1'b0;
      mul_a     <= '0;
      mul_b     <= '0;
      result    <= '0;
`ifdef MUL_ARB_RR_EN
      rr_ptr    <= 1'b0;
`endif
    end else begin
      mul_start <= 1'b0;
      done0     <= 1'b0;
      done1     <= 1'b0;
      case (state)
        MARB_IDLE: begin
          // A still-busy multiplier is a stale run: never launch over it.
          if (!mul_stall && (req0 || req1)) begin
            if (win_c[1]) begin
              mul_a <= a1;
              mul_b <= b1;
              gnt1  <= 1'b1;
            end else begin
              mul_a <= a0;
              mul_b <= b0;
              gnt0  <= 1'b1;
            end
`ifdef MUL_ARB_RR_EN
            rr_ptr <= win_c[0];
`endif
            mul_start <= 1'b1;
            state     <= MARB_LAUNCH;
          end
        end
        MARB_LAUNCH: begin
          wait_cnt <= '0;
          state    <= MARB_WAIT_BUSY;
        end
        MARB_WAIT_BUSY: begin
          if (mul_stall) begin
            state <= MARB_WAIT_DONE;
          end else if (wait_cnt == CW'(WAIT_MAX - 1)) begin
            err    <= 1'b1;
            result <= '0;
            done0  <= gnt0;
            done1  <= gnt1;
            state  <= MARB_RESP;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        MARB_WAIT_DONE: begin
          if (!mul_stall) begin
            result <= mul_result;
            done0  <= gnt0;
            done1  <= gnt1;
            state  <= MARB_RESP;
          end
        end
        MARB_RESP: begin
          gnt0  <= 1'b0;
          gnt1  <= 1'b0;
          state <= MARB_IDLE;
        end
        default: begin
          state <= MARB_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_arbiter.sv
// Self-checking bench for mul_arbiter with a behavioural iterative multiplier.
module tb_mul_arbiter;

  localparam int unsigned SIZE     = 64;
  localparam int unsigned WAIT_MAX = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            req0 = 1'b0, req1 = 1'b0;
  logic [SIZE-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic            gnt0, gnt1, done0, done1, mul_start, err;
  logic [SIZE-1:0] result, mul_a, mul_b;

  // Multiplier model state.
  logic            m_stall = 1'b0;
  logic            start_q = 1'b0;
  logic [SIZE-1:0] m_res = '0;
  logic [SIZE-1:0] m_prod = '0;
  int              m_cnt = 0;
  int              lat = 2;
  bit              stuck = 1'b0;

  int errors = 0;
  int checks = 0;
  int last_gnt = 1;
  int both_cnt = 0, start_cnt = 0, d0_cnt = 0, g1_seen = 0, stab_bad = 0;

  always #5 clk = ~clk;

  mul_arbiter #(.SIZE(SIZE), .WAIT_MAX(WAIT_MAX)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0       (req0),
    .req1       (req1),
    .a0         (a0),
    .b0         (b0),
    .a1         (a1),
    .b1         (b1),
    .gnt0       (gnt0),
    .gnt1       (gnt1),
    .done0      (done0),
    .done1      (done1),
    .result     (result),
    .mul_start  (mul_start),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_result (m_res),
    .mul_stall  (m_stall),
    .err        (err)
  );

  // Iterative multiplier: rising mul_start begins a run of lat+1 busy cycles.
  always @(posedge clk) begin
    start_q <= mul_start;
    if (mul_start && !start_q && !stuck) begin
      m_stall <= 1'b1;
      m_cnt   <= lat;
      m_prod  <= mul_a * mul_b;
    end else if (m_stall) begin
      if (m_cnt == 0) begin
        m_stall <= 1'b0;
        m_res   <= m_prod;
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end
  end

  // Protocol monitors sampled away from the active edge.
  always @(negedge clk) begin
    if (gnt0 && gnt1) both_cnt++;
    if (mul_start) start_cnt++;
    if (done0) d0_cnt++;
    if (gnt1) g1_seen++;
    if (gnt0 && (mul_a !== a0 || mul_b !== b0)) stab_bad++;
    if (gnt1 && (mul_a !== a1 || mul_b !== b1)) stab_bad++;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "bench did not finish");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] prod(input logic [63:0] x, input logic [63:0] y);
    logic [127:0] p;
    p = x * y;
    return p[63:0];
  endfunction

  // Reference arbitration: lone requester wins; contention by policy.
  function automatic int pick_model(input bit r0, input bit r1);
    if (r0 && !r1) return 0;
    if (r1 && !r0) return 1;
`ifdef MUL_ARB_RR_EN
    return (last_gnt == 0) ? 1 : 0;
`else
    return 0;
`endif
  endfunction

  task automatic wait_done(output logic d0, output logic d1, output logic [63:0] r);
    d0 = 1'b0; d1 = 1'b0; r = '0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done0 || done1) begin
        d0 = done0; d1 = done1; r = result;
        return;
      end
    end
    checks++;
    errors++;
    $error("FAIL done_timeout observed=no done expected=done within 200 cycles");
  endtask

  task automatic serve(input int who, input logic [63:0] exp_r, input string tag);
    logic d0, d1;
    logic [63:0] r;
    wait_done(d0, d1, r);
    check({tag, "_who"}, 64'({d1, d0}), (who == 1) ? 64'd2 : 64'd1);
    check({tag, "_res"}, r, exp_r);
    if (d0) req0 = 1'b0;
    if (d1) req1 = 1'b0;
    last_gnt = who;
    @(negedge clk);
    check({tag, "_gnt_drop"}, 64'({gnt1, gnt0}), 64'd0);
  endtask

  task automatic wait_cond_start(output bit found);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (mul_start) found = 1'b1;
    end
  endtask

  initial begin
    int w, n, s0, d0s, bad;
    bit found;

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_ctrl", 64'({gnt0, gnt1, done0, done1, mul_start, err}), 64'd0);
    check("rst_mul_a", mul_a, 64'd0);
    check("rst_mul_b", mul_b, 64'd0);
    check("rst_result", result, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Simultaneous requests from a fresh pointer.
    a0 = 64'd3; b0 = 64'd5; a1 = 64'd9; b1 = 64'd9;
    req0 = 1'b1; req1 = 1'b1;
    w = pick_model(1'b1, 1'b1);
    check("pair_first_is_0", 64'(w), 64'd0);
    serve(w, (w == 0) ? 64'd15 : 64'd81, "pair_a");
    w = pick_model(req0, req1);
    serve(w, (w == 0) ? 64'd15 : 64'd81, "pair_b");

    // Single requester 0: 6 x 7.
    s0 = start_cnt; d0s = d0_cnt; g1_seen = 0;
    a0 = 64'd6; b0 = 64'd7; req0 = 1'b1;
    serve(0, 64'd42, "basic");
    check("basic_starts", 64'(start_cnt - s0), 64'd1);
    check("basic_dones", 64'(d0_cnt - d0s), 64'd1);
    check("basic_gnt1", 64'(g1_seen), 64'd0);

    // Contention after requester 0 was last served.
    a0 = 64'd11; b0 = 64'd13; a1 = 64'd17; b1 = 64'd19;
    req0 = 1'b1; req1 = 1'b1;
    w = pick_model(1'b1, 1'b1);
    serve(w, (w == 0) ? 64'd143 : 64'd323, "fair_a");
    w = pick_model(req0, req1);
    serve(w, (w == 0) ? 64'd143 : 64'd323, "fair_b");

    // Wrap-around product, operands must stay stable throughout.
    lat = 4;
    a0 = 64'hFFFF_FFFF_FFFF_FFFF; b0 = 64'd2; req0 = 1'b1;
    serve(0, 64'hFFFF_FFFF_FFFF_FFFE, "wrap");

    // Withdrawal: requester drops req after grant; done still pulses.
    a1 = 64'd6; b1 = 64'd6; req1 = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (gnt1) found = 1'b1;
    end
    check("withdraw_gnt", 64'(found), 64'd1);
    req1 = 1'b0;
    serve(1, 64'd36, "withdraw");

    // Randomized traffic against the reference model.
    for (int it = 0; it < 16; it++) begin
      int pat;
      pat = $urandom_range(1, 3);
      lat = $urandom_range(0, 4);
      a0 = {$urandom, $urandom}; b0 = {$urandom, $urandom};
      a1 = {$urandom, $urandom}; b1 = {$urandom, $urandom};
      req0 = pat[0]; req1 = pat[1];
      for (int k = 0; k < 2 && (req0 || req1); k++) begin
        w = pick_model(req0, req1);
        serve(w, (w == 0) ? prod(a0, b0) : prod(a1, b1), "rand");
      end
    end

    // Multiplier never raises stall: timeout path.
    stuck = 1'b1;
    a0 = 64'd3; b0 = 64'd3; req0 = 1'b1;
    wait_cond_start(found);
    check("stuck_launch", 64'(found), 64'd1);
    n = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      n++;
      if (done0) break;
    end
    check("stuck_latency", 64'(n), 64'(WAIT_MAX + 1));
    check("stuck_result", result, 64'd0);
    check("stuck_err", 64'(err), 64'd1);
    req0 = 1'b0;
    last_gnt = 0;
    @(negedge clk);
    check("stuck_idle_gnt", 64'({gnt1, gnt0}), 64'd0);
    stuck = 1'b0;
    lat = 1;
    a1 = 64'd5; b1 = 64'd4; req1 = 1'b1;
    serve(1, 64'd20, "after_err");
    check("err_sticky", 64'(err), 64'd1);

    // Reset during WAIT_DONE leaves a stale busy run behind.
    lat = 30;
    a0 = 64'd5; b0 = 64'd5; req0 = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (m_stall) found = 1'b1;
    end
    check("rst_mid_busy", 64'(found), 64'd1);
    repeat (2) @(negedge clk);
    d0s = d0_cnt;
    rst_n = 1'b0;
    req0 = 1'b0;
    #1;
    check("rst_mid_ctrl", 64'({gnt0, gnt1, done0, done1, mul_start, err}), 64'd0);
    check("rst_mid_regs", mul_a | mul_b | result, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    last_gnt = 1;
    check("stale_present", 64'(m_stall), 64'd1);
    lat = 2;
    a1 = 64'd2; b1 = 64'h0000_0000_FFFF_FFFF; req1 = 1'b1;
    bad = 0;
    for (int i = 0; i < 100 && m_stall; i++) begin
      @(negedge clk);
      if (m_stall && (mul_start || gnt1)) bad++;
    end
    check("stale_no_launch", 64'(bad), 64'd0);
    serve(1, 64'h1_FFFF_FFFE, "post_rst");
    check("rst_no_done0", 64'(d0_cnt - d0s), 64'd0);

    // Global protocol invariants.
    check("gnt_exclusive", 64'(both_cnt), 64'd0);
    check("operand_stable", 64'(stab_bad), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mul_arbiter.md
MUL_ARBITER -- requirements
Module: mul_arbiter

Interface
REQ-001 Parameter SIZE, default `WORD, operand/result width.
REQ-002 Parameter WAIT_MAX, default 4, max cycles from launch to observed mul_stall rise.
REQ-003 clk  in  1  single clock; all state on posedge clk.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 req0, req1  in  1 each  requester N wants a product; held high with operands stable until doneN.
REQ-006 a0, b0, a1, b1  in  SIZE each  operands of requester 0/1.
REQ-007 gnt0, gnt1  out  1 each  requester N owns the multiplier; high from grant through doneN.
REQ-008 done0, done1  out  1 each  one-cycle pulse, product for requester N valid.
REQ-009 result  out  SIZE  low SIZE bits of product, valid only while done0 or done1 is high.
REQ-010 mul_start  out  1  start to the shared iterative multiplier, rising edge launches.
REQ-011 mul_a, mul_b  out  SIZE each  operands to the multiplier, registered.
REQ-012 mul_result  in  SIZE  multiplier product.
REQ-013 mul_stall  in  1  multiplier busy.
REQ-014 err  out  1  sticky: mul_stall never rose within WAIT_MAX cycles of a launch.

Function
REQ-015 States: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, RESP; encoded in 3 bits.
REQ-016 IDLE: when mul_stall low and any req high, pick winner, latch its operands into mul_a/mul_b, assert its gnt, go LAUNCH.
REQ-017 IDLE with mul_stall high (stale run) shall not launch; it waits until mul_stall is low.
REQ-018 LAUNCH: mul_start high for exactly one cycle, then WAIT_BUSY.
REQ-019 WAIT_BUSY: mul_stall high -> WAIT_DONE; after WAIT_MAX cycles without it -> set err, go RESP with result = 0.
REQ-020 WAIT_DONE: on first cycle mul_stall is sampled low, capture mul_result into result, go RESP.
REQ-021 RESP: pulse doneN for the granted requester, drop gnt on the next edge, return to IDLE; result holds until the next capture.
REQ-022 Back-to-back: requester may reassert req the cycle after done; the earliest next grant is the cycle after RESP.
REQ-023 Granted req falling before done (withdrawal): the operation completes, done is still pulsed, and the product is discarded by the requester.
REQ-024 Simultaneous req0 and req1 in IDLE: winner per REQ-030/031; loser keeps req high and is served next.
REQ-025 At most one gnt high at any time; gnt only changes in IDLE or after RESP.
REQ-026 mul_a/mul_b are stable from LAUNCH through RESP.

Reset
REQ-027 rst_n low: state IDLE; gnt0, gnt1, done0, done1, mul_start, err = 0; mul_a, mul_b, result = 0; rr pointer = 0.
REQ-028 Reset mid-operation abandons the run without a done pulse; REQ-017 then masks the multiplier's stale stall.
REQ-029 err clears only on reset.

Configuration
REQ-030 MUL_ARB_RR_EN defined: round-robin; a 1-bit pointer favours the requester not granted last and toggles on each grant.
REQ-031 MUL_ARB_RR_EN undefined: fixed priority, req0 always wins; no pointer register exists.

Structure
REQ-032 Shared constants.vh holds `WORD and the state encodings (MARB_IDLE..MARB_RESP).
REQ-033 One sub-module, mul_arb_pick, is combinational: it takes req0, req1, and the pointer and returns a one-hot winner; the RR/fixed choice lives there.
REQ-034 The multiplier is instantiated outside mul_arbiter and connected only through the mul_* ports.

Verification (bench wires in the real multiplier, SIZE=64)
REQ-035 req0 with a0=6, b0=7 -> gnt0, one mul_start pulse, done0 once with result=42, gnt1 never high.
REQ-036 req0 and req1 rise together (3x5, 9x9), RR_EN -> done0 result=15 then done1 result=81; with the second pair also, the next grant goes to 1 first. Without RR_EN -> 0 always first.
REQ-037 Stuck-low stall model -> err=1 after WAIT_MAX cycles, done pulses with result=0, and the arbiter returns to IDLE.
REQ-038 rst_n pulsed low mid-WAIT_DONE -> all outputs 0 immediately; a new req1 (2x0xFFFFFFFF) launches only after stale stall falls, result=0x1FFFFFFFE.
REQ-039 a0=0xFFFFFFFFFFFFFFFF, b0=2 -> result=0xFFFFFFFFFFFFFFFE (low 64 bits); gnt0 held throughout, mul_a/mul_b unchanged until RESP.
